// File: rtl/calc2_port_driver_if.sv
// Host-side and calc2-side signal bundle for calc2_port_driver.
// master = the driver itself, slave = the host plus calc2 port it talks to.
interface calc2_port_driver_if;
  logic        host_valid;
  logic        host_ready;
  logic [0:3]  host_cmd;
  logic [0:31] host_op1;
  logic [0:31] host_op2;

  logic [0:3]  req_cmd_out;
  logic [0:31] req_data_out;
  logic [0:1]  req_tag_out;

  logic [0:1]  out_resp_in;
  logic [0:31] out_data_in;
  logic [0:1]  out_tag_in;

  logic        rsp_valid;
  logic [0:1]  rsp_resp;
  logic [0:31] rsp_data;
  logic [0:1]  rsp_tag;

  logic        busy;
  logic        proto_err;
  logic        timeout_err;

  modport master (
    input  host_valid, host_cmd, host_op1, host_op2,
    input  out_resp_in, out_data_in, out_tag_in,
    output host_ready,
    output req_cmd_out, req_data_out, req_tag_out,
    output rsp_valid, rsp_resp, rsp_data, rsp_tag,
    output busy, proto_err, timeout_err
  );

  modport slave (
    output host_valid, host_cmd, host_op1, host_op2,
    output out_resp_in, out_data_in, out_tag_in,
    input  host_ready,
    input  req_cmd_out, req_data_out, req_tag_out,
    input  rsp_valid, rsp_resp, rsp_data, rsp_tag,
    input  busy, proto_err, timeout_err
  );
endinterface

// File: rtl/calc2_port_driver.sv
// Per-port calc2 request driver: host FIFO, 2-bit tag allocation, CMD/DATA2 serialiser, response matcher.
// Optional per-tag response watchdog enabled by defining CALC2_DRV_TIMEOUT_EN.
module calc2_port_driver #(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                 c_clk,
  input  logic                 reset,
  calc2_port_driver_if.master  bus
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_CMD   = 2'd1;
  localparam logic [1:0] ST_DATA2 = 2'd2;

  logic [0:3]    fifo_cmd [FIFO_DEPTH];
  logic [0:31]   fifo_op1 [FIFO_DEPTH];
  logic [0:31]   fifo_op2 [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;

  logic [1:0]    state;
  logic [1:0]    state_nxt;

  logic [3:0]    tag_busy;
  logic [3:0]    tag_set;
  logic [3:0]    tag_clr;
  logic [3:0]    rsp_clr;
  logic [3:0]    tmo_clr;
  logic [1:0]    alloc_tag;
  logic          tag_free;

  logic          push;
  logic          pop;
  logic          resp_hit;

  logic          vld_p1;
  logic [0:1]    resp_p1;
  logic [0:31]   data_p1;
  logic [0:1]    tag_p1;
  logic          proto_err_q;

  function automatic logic [1:0] lowest_free(input logic [3:0] v);
    if (!v[0])      lowest_free = 2'd0;
    else if (!v[1]) lowest_free = 2'd1;
    else if (!v[2]) lowest_free = 2'd2;
    else            lowest_free = 2'd3;
  endfunction

  // Ready is derived from the registered count only, so a DATA2 pop never frees a slot in the same cycle.
  assign bus.host_ready = (count != CW'(FIFO_DEPTH));
  assign push           = bus.host_valid && bus.host_ready && (bus.host_cmd != 4'h0);
  assign pop            = (state == ST_DATA2);

  assign alloc_tag = lowest_free(tag_busy);
  assign tag_free  = ~&tag_busy;
  assign resp_hit  = (bus.out_resp_in != 2'b00);

  always_ff @(posedge c_clk) begin
    if (push) begin
      fifo_cmd[wr_ptr] <= bus.host_cmd;
      fifo_op1[wr_ptr] <= bus.host_op1;
      fifo_op2[wr_ptr] <= bus.host_op2;
    end
  end

  always_ff @(posedge c_clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // An operation pushed this cycle counts as available, giving CMD on the very next cycle.
  always_comb begin
    state_nxt = ST_IDLE;
    case (state)
      ST_IDLE:  if (((count != '0) || push) && tag_free) state_nxt = ST_CMD;
      ST_CMD:   state_nxt = ST_DATA2;
      ST_DATA2: if (((count > CW'(1)) || push) && tag_free) state_nxt = ST_CMD;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge c_clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    bus.req_cmd_out  = '0;
    bus.req_data_out = '0;
    bus.req_tag_out  = '0;
    case (state)
      ST_CMD: begin
        bus.req_cmd_out  = fifo_cmd[rd_ptr];
        bus.req_data_out = fifo_op1[rd_ptr];
        bus.req_tag_out  = alloc_tag;
      end
      ST_DATA2: bus.req_data_out = fifo_op2[rd_ptr];
      default: ;
    endcase
  end

  always_comb begin
    rsp_clr = '0;
    if (resp_hit) rsp_clr[bus.out_tag_in] = 1'b1;
  end

  assign tag_set = (state == ST_CMD) ? (4'b0001 << alloc_tag) : 4'b0000;
  assign tag_clr = rsp_clr | tmo_clr;

  // Clear before set: a tag freed this cycle is only visible to the allocator next cycle.
  always_ff @(posedge c_clk or negedge reset) begin
    if (!reset) tag_busy <= '0;
    else        tag_busy <= (tag_busy & ~tag_clr) | tag_set;
  end

`ifdef CALC2_DRV_TIMEOUT_EN
  localparam logic [8:0] TMO_LIM = 9'(TIMEOUT_CYCLES);

  logic [7:0] tmo_cnt [4];
  logic [3:0] tmo_exp;
  logic       tmo_pulse;

  // A response for the same tag in the expiry cycle wins over the watchdog.
  always_comb begin
    tmo_exp = '0;
    for (int i = 0; i < 4; i++) begin
      tmo_exp[i] = tag_busy[i] && (({1'b0, tmo_cnt[i]} + 9'd1) >= TMO_LIM) && !rsp_clr[i];
    end
  end

  always_ff @(posedge c_clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 4; i++) tmo_cnt[i] <= '0;
      tmo_pulse <= 1'b0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (tag_set[i])                    tmo_cnt[i] <= 8'd1;
        else if (tag_busy[i] && !tag_clr[i]) tmo_cnt[i] <= tmo_cnt[i] + 8'd1;
      end
      tmo_pulse <= |tmo_exp;
    end
  end

  assign tmo_clr         = tmo_exp;
  assign bus.timeout_err = tmo_pulse;
`else
  logic [7:0] tmo_unused;

  assign tmo_unused      = 8'(TIMEOUT_CYCLES);
  assign tmo_clr         = '0;
  assign bus.timeout_err = 1'b0;
`endif

  // Response stage: calc2 response registered one cycle before reaching the host.
  always_ff @(posedge c_clk or negedge reset) begin
    if (!reset) begin
      vld_p1      <= 1'b0;
      resp_p1     <= '0;
      data_p1     <= '0;
      tag_p1      <= '0;
      proto_err_q <= 1'b0;
    end else begin
      vld_p1 <= resp_hit;
      if (resp_hit) begin
        resp_p1 <= bus.out_resp_in;
        data_p1 <= bus.out_data_in;
        tag_p1  <= bus.out_tag_in;
        if (!tag_busy[bus.out_tag_in]) proto_err_q <= 1'b1;
      end
    end
  end

  assign bus.rsp_valid = vld_p1;
  assign bus.rsp_resp  = resp_p1;
  assign bus.rsp_data  = data_p1;
  assign bus.rsp_tag   = tag_p1;
  assign bus.busy      = |tag_busy;
  assign bus.proto_err = proto_err_q;

endmodule
